// File: rtl/histogram_cdf.sv
// Histogram-to-CDF stage: streams 32 packed histogram words from scratch memory,
// writes the saturating running prefix sum back, and reports cdf_min and the pixel total.
module histogram_cdf #(
  parameter logic [15:0] HIST_BASE_ADDR = 16'h0000,
  parameter logic [15:0] CDF_BASE_ADDR  = 16'h0020,
  parameter int          NUM_WORDS      = 32,
  parameter int          BIN_WIDTH      = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_cdf,
  input  logic [127:0] scratch_memory_rdata0,
  output logic [15:0]  scratch_memory_address_pointer0,
  output logic         write_enable,
  output logic [15:0]  write_address,
  output logic [127:0] scratch_memory_wdata,
  output logic [15:0]  cdf_min,
  output logic [16:0]  cdf_total,
  output logic         cdf_overflow,
  output logic         cdf_busy,
  output logic         cdf_computation_done
);

  localparam int LANES = 128 / BIN_WIDTH;
  localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_r;
  logic [15:0]   issue_idx_r;
  logic [15:0]   wr_idx_r;
  logic [16:0]   acc_r;
  logic          min_found_r;
  logic          rd_valid_r;

  logic [127:0]  cdf_word_s;
  logic [16:0]   sum_s;
  logic          any_ovf_s;
  logic          nz_found_s;
  logic [15:0]   nz_val_s;

  // Eight-lane prefix chain over the word currently on the read bus.
  always_comb begin
    logic [16:0] run_v;
    run_v      = acc_r;
    any_ovf_s  = 1'b0;
    nz_found_s = 1'b0;
    nz_val_s   = 16'h0000;
    cdf_word_s = 128'h0;
    for (int k = 0; k < LANES; k++) begin
      run_v = run_v + 17'(scratch_memory_rdata0[BIN_WIDTH*k +: BIN_WIDTH]);
      if (run_v > 17'h0FFFF) begin
        cdf_word_s[BIN_WIDTH*k +: BIN_WIDTH] = 16'hFFFF;
        any_ovf_s = 1'b1;
      end else begin
        cdf_word_s[BIN_WIDTH*k +: BIN_WIDTH] = run_v[15:0];
      end
      // Lowest non-zero lane wins within the word.
      if (!nz_found_s && (scratch_memory_rdata0[BIN_WIDTH*k +: BIN_WIDTH] != 16'h0000)) begin
        nz_found_s = 1'b1;
        nz_val_s   = cdf_word_s[BIN_WIDTH*k +: BIN_WIDTH];
      end else begin
        nz_found_s = nz_found_s;
      end
    end
    sum_s = run_v;
  end

  // Control FSM, read issue, registered write-back and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r                         <= IDLE;
      issue_idx_r                     <= 16'h0000;
      wr_idx_r                        <= 16'h0000;
      acc_r                           <= 17'h00000;
      min_found_r                     <= 1'b0;
      rd_valid_r                      <= 1'b0;
      scratch_memory_address_pointer0 <= HIST_BASE_ADDR;
      write_enable                    <= 1'b0;
      write_address                   <= 16'h0000;
      scratch_memory_wdata            <= 128'h0;
      cdf_min                         <= 16'h0000;
      cdf_total                       <= 17'h00000;
      cdf_overflow                    <= 1'b0;
      cdf_busy                        <= 1'b0;
      cdf_computation_done            <= 1'b0;
    end else begin
      write_enable <= rd_valid_r;
      if (rd_valid_r) begin
        scratch_memory_wdata <= cdf_word_s;
        write_address        <= CDF_BASE_ADDR + wr_idx_r;
        wr_idx_r             <= wr_idx_r + 16'h0001;
        acc_r                <= sum_s;
        if (any_ovf_s) cdf_overflow <= 1'b1;
        if (!min_found_r && nz_found_s) begin
          cdf_min     <= nz_val_s;
          min_found_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          scratch_memory_address_pointer0 <= HIST_BASE_ADDR;
          cdf_computation_done            <= 1'b0;
          rd_valid_r                      <= 1'b0;
          if (start_cdf) begin
            acc_r        <= 17'h00000;
            cdf_min      <= 16'h0000;
            cdf_overflow <= 1'b0;
            min_found_r  <= 1'b0;
            issue_idx_r  <= 16'h0000;
            wr_idx_r     <= 16'h0000;
            cdf_busy     <= 1'b1;
            state_r      <= RUN;
          end
        end
        RUN: begin
          rd_valid_r <= 1'b1;
          if (issue_idx_r == LAST_WORD) begin
            state_r <= DRAIN;
          end else begin
            scratch_memory_address_pointer0 <= scratch_memory_address_pointer0 + 16'h0001;
            issue_idx_r                     <= issue_idx_r + 16'h0001;
          end
        end
        DRAIN: begin
          rd_valid_r <= 1'b0;
          if (!rd_valid_r) begin
            cdf_busy             <= 1'b0;
            cdf_computation_done <= 1'b1;
            cdf_total            <= acc_r;
            state_r              <= DONE;
          end
        end
        DONE: begin
          cdf_computation_done <= 1'b0;
          state_r              <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/histogram_cdf.md
Name: histogram_cdf

Overview:
Stage directly downstream of the histogram stage in the histogram-equalisation pipeline. It starts when the histogram stage finishes, then reads the 256-bin histogram from scratch memory, which is 128-bit wide with 16-bit addressing. It computes the cumulative distribution function (CDF) as a running prefix sum and writes the CDF back to scratch memory at a separate base. It also reports cdf_min (CDF of the first non-zero bin) and the pixel total, which the equalisation-mapping stage consumes.

Parameters:
HIST_BASE_ADDR, 16'h0000, scratch address of histogram word 0
CDF_BASE_ADDR, 16'h0020, scratch address of CDF word 0
NUM_WORDS, 32, histogram words (8 bins/word, 256 bins)
BIN_WIDTH, 16, bits per bin; fixed at 16 (8 x 16 = 128)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
start_cdf  in  1  start request (level or pulse; sampled only in IDLE); tied to histogram_computation_done
scratch_memory_rdata0  in  128  scratch read data
scratch_memory_address_pointer0  out  16  scratch read address
write_enable  out  1  scratch write strobe
write_address  out  16  scratch write address
scratch_memory_wdata  out  128  scratch write data (CDF word)
cdf_min  out  16  CDF value of first non-zero bin
cdf_total  out  17  final sum of all bins
cdf_overflow  out  1  sticky: sum exceeded 16'hFFFF
cdf_busy  out  1  high in RUN/DRAIN
cdf_computation_done  out  1  one-cycle completion pulse

Behaviour:
- One clock domain; reset is synchronous and active-high, named clock/reset.
- Packing: bin index = 8*w + k; bin k of word w in bits [16k+15:16k]. Same layout for CDF words.
- Reset values:
  - scratch_memory_address_pointer0 = HIST_BASE_ADDR
  - write_enable = 0, write_address = 0, scratch_memory_wdata = 0
  - cdf_min = 0, cdf_total = 0, cdf_overflow = 0, cdf_busy = 0, cdf_computation_done = 0
  - FSM = IDLE, internal accumulator and min-found flag cleared
- FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Pointer held at HIST_BASE_ADDR.
  - Edge E0 samples start_cdf=1: clear accumulator (17-bit), cdf_min, cdf_overflow and min-found flag; go to RUN.
- Memory read latency is fixed at 1 cycle: the address driven in cycle c gives data valid in cycle c+1.
- RUN:
  - Read address for word w is driven in cycle 1+w after E0 (pointer = HIST_BASE_ADDR + w), incrementing every edge.
  - After w = NUM_WORDS-1 has been issued, go to DRAIN.
- Data word w is captured at the end of cycle 2+w. Computation for that word:
  - 8-stage prefix chain: s_k = acc + sum(bin_0..bin_k), each 17 bits.
  - Stored CDF lane k = (s_k > 16'hFFFF) ? 16'hFFFF : s_k[15:0] (saturating).
  - Accumulator updated to s_7.
  - If any s_k > 16'hFFFF, set cdf_overflow (sticky until next start).
  - min-found clear and a lane has bin_k != 0 (lowest such k in the lowest such word): cdf_min <= that lane's saturated CDF value; set min-found.
- Writes are registered: in cycle 3+w, write_enable=1, write_address = CDF_BASE_ADDR + w, scratch_memory_wdata = CDF word. write_enable=0 in every other cycle.
- DRAIN: lasts until the last write (cycle NUM_WORDS+2 = 34). cdf_busy=1 from cycle 1 through cycle 34.
- DONE: cycle NUM_WORDS+3 = 35.
  - cdf_computation_done=1 for exactly one cycle; cdf_total = accumulator.
  - Return to IDLE.
- cdf_min, cdf_total and cdf_overflow hold until the next start or reset.
- All bins zero: cdf_min=0, cdf_total=0, every CDF word 0.
- start_cdf while RUN/DRAIN/DONE is ignored. If start_cdf is still high in IDLE after DONE, a new run starts (level-start).
- Reset mid-operation: at the next edge all outputs return to reset values, no further writes, FSM = IDLE.
- Address arithmetic is 16-bit modulo; no range check.

Test Plan:
- All 256 bins = 1, start pulse:
  - CDF word 0 = {16'd8,7,6,5,4,3,2,16'd1} (lane 7..0).
  - Word 31 lane 7 = 256.
  - cdf_min=1, cdf_total=256, overflow=0.
  - 32 writes to 0x20..0x3F in cycles 3..34; done pulse in cycle 35 only.
- Only bin 100 = 16'd4096, rest 0:
  - CDF lanes for bins 0..99 = 0, bins 100..255 = 4096.
  - cdf_min=4096, cdf_total=4096.
- All bins = 256 (65536 pixels):
  - Bin 254 CDF = 65280; bin 255 CDF = 16'hFFFF.
  - cdf_total=17'h10000, cdf_overflow=1.
- All bins zero: every CDF word 0, cdf_min=0, cdf_total=0, done in cycle 35.
- start_cdf toggled in cycle 10 during RUN:
  - Run unaffected; exactly 32 writes, one done pulse.
  - A second start after returning to IDLE clears overflow and cdf_min and repeats.
- reset asserted in cycle 15:
  - Next cycle write_enable=0, pointer=HIST_BASE_ADDR, busy=0, all flags 0.
  - No done pulse.
  - A fresh start then completes normally.
